// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: RAM port state, word type, responder FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } dresp_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath-side request bus (dmem_if) and RAM/arbiter-side port (ram_if) for dmem_responder.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              halt;
    logic              dmemREN;
    logic              dmemWEN;
    logic              datomic;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              derr;

    modport master (
        output halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dhit, dmemload, derr
    );
    modport slave (
        input  halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dhit, dmemload, derr
    );
endinterface

interface ram_if
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );
    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/dmem_link_reg.sv
// LL/SC link register: set by a completed LL, cleared by a completed store to the linked word
// (and, with LINK_SNOOP_EN, by a snooped remote write). hit_o qualifies an SC presented in IDLE.
module dmem_link_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] upd_addr_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
`ifdef LINK_SNOOP_EN
    input  logic              snoop_valid_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
`endif
    output logic              hit_o
);
    // Word-granular compare: byte offset bits are masked out.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              local_clr;
    logic              snoop_clr;

    assign local_clr = clr_i && (((upd_addr_i ^ addr_q) & WORD_MASK) == '0);
`ifdef LINK_SNOOP_EN
    assign snoop_clr = snoop_valid_i && (((snoop_addr_i ^ addr_q) & WORD_MASK) == '0);
`else
    assign snoop_clr = 1'b0;
`endif

    // A snoop landing in the same cycle as the SC check already makes the SC lose.
    assign hit_o = valid_q && !snoop_clr && (((chk_addr_i ^ addr_q) & WORD_MASK) == '0);

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (local_clr || snoop_clr) valid_d = 1'b0;
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = upd_addr_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one RAM transaction per held datapath request, dhit/dmemload return,
// LL/SC link ownership. Optional `LINK_SNOOP_EN adds snoop_valid/snoop_addr link invalidation.
module dmem_responder
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    dmem_if.slave             dp,
    ram_if.master             ram
`ifdef LINK_SNOOP_EN
    ,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr
`endif
);
    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [DATA_W-1:0] SC_OK   = {{(DATA_W-1){1'b0}}, 1'b1};

    dresp_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              derr_q, derr_d;
    logic              atom_q, atom_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic link_hit, link_set, link_clr;

    dmem_link_reg #(.ADDR_W(ADDR_W)) u_link (
        .CLK          (CLK),
        .nRST         (nRST),
        .set_i        (link_set),
        .clr_i        (link_clr),
        .upd_addr_i   (addr_q),
        .chk_addr_i   (dp.dmemaddr),
`ifdef LINK_SNOOP_EN
        .snoop_valid_i(snoop_valid),
        .snoop_addr_i (snoop_addr),
`endif
        .hit_o        (link_hit)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        load_d   = load_q;
        derr_d   = 1'b0;
        atom_d   = atom_q;
        cnt_d    = cnt_q;
        link_set = 1'b0;
        link_clr = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!dp.halt) begin
                    if (dp.dmemWEN) begin
                        // REN together with WEN is malformed: flag it, service the write.
                        derr_d  = dp.dmemREN;
                        addr_d  = dp.dmemaddr;
                        store_d = dp.dmemstore;
                        atom_d  = dp.datomic;
                        if (dp.datomic && !link_hit) begin
                            load_d  = '0;
                            state_d = RESP;
                        end else begin
                            state_d = WRITE;
                        end
                    end else if (dp.dmemREN) begin
                        addr_d  = dp.dmemaddr;
                        atom_d  = dp.datomic;
                        state_d = READ;
                    end
                end
            end
            READ, WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ram.ramstate == ACCESS) begin
                    state_d = RESP;
                    if (state_q == READ) begin
                        load_d   = ram.ramload;
                        link_set = atom_q;
                    end else begin
                        load_d   = atom_q ? SC_OK : '0;
                        link_clr = 1'b1;
                    end
                end else if (ram.ramstate == ERROR || cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    derr_d  = 1'b1;
                    load_d  = '0;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            derr_q  <= 1'b0;
            atom_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            load_q  <= load_d;
            derr_q  <= derr_d;
            atom_q  <= atom_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dp.dhit      = (state_q == RESP);
    assign dp.dmemload  = load_q;
    assign dp.derr      = derr_q;
    assign ram.ramREN   = (state_q == READ);
    assign ram.ramWEN   = (state_q == WRITE);
    assign ram.ramaddr  = addr_q;
    assign ram.ramstore = store_q;

endmodule
